// File: rtl/reg_file_param.sv
// Parameterised register file with two combinational read ports, one data write port
// and a dedicated link-register write port, plus a sequential clear engine.
// Latency: reads are combinational; writes land at the rising edge.
// Backpressure: the clear takes NUM_REGS cycles with ready low, and writes are dropped then (wr_err pulse).
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   Rn, Rm               - read indices for ports A and B
//   Rd, data_write       - data write index and value
//   return_address       - value written to the link register
//   reg_wr               - write mode: bit0 Rd write, bit1 link write
//   clr_req              - request a full-file clear (taken only while ready)
//   Reg_Rn, Reg_Rm       - read data for ports A and B
//   ready                - file is out of clear and accepting writes
//   wr_err               - one-cycle pulse, a write was dropped during the clear
module reg_file_param #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ZR_IDX   = NUM_REGS - 1,
    parameter int LR_IDX   = NUM_REGS - 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     Rn,
    input  logic [AW-1:0]     Rm,
    input  logic [AW-1:0]     Rd,
    input  logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] return_address,
    input  logic [1:0]        reg_wr,
    input  logic              clr_req,
    output logic [DATA_W-1:0] Reg_Rn,
    output logic [DATA_W-1:0] Reg_Rm,
    output logic              ready,
    output logic              wr_err
);

    localparam logic [AW-1:0] ZR_A     = AW'(ZR_IDX);
    localparam logic [AW-1:0] LR_A     = AW'(LR_IDX);
    localparam logic [AW-1:0] CNT_LAST = AW'(NUM_REGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_err_q, wr_err_d;

    // Storage has no reset: a reset always forces a full clear sweep and
    // reads are masked to zero until the sweep completes.
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic clr_en;
    logic wr_rd_en;
    logic wr_lr_en;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_err_d = 1'b0;
        clr_en   = 1'b0;
        wr_rd_en = 1'b0;
        wr_lr_en = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_en   = 1'b1;
                // Any write attempt during the sweep is discarded and flagged.
                wr_err_d = |reg_wr;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                wr_rd_en = reg_wr[0] && (Rd != ZR_A);
                wr_lr_en = reg_wr[1] && (LR_A != ZR_A);
                // Writes in the request cycle still complete; the sweep
                // starts from index 0 on the next edge.
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array. The link write is placed last so it wins when
    // Rd targets the link register in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs_q[cnt_q] <= '0;
        end
        if (wr_rd_en) begin
            regs_q[Rd] <= data_write;
        end
        if (wr_lr_en) begin
            regs_q[LR_A] <= return_address;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     idx,
        input state_t            st,
        input logic              rd_en,
        input logic              lr_en,
        input logic [AW-1:0]     wr_idx,
        input logic [DATA_W-1:0] wr_dat,
        input logic [DATA_W-1:0] lr_dat,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (st != ST_READY || idx == ZR_A) begin
            val = '0;
        end else if (BYPASS != 0 && lr_en && idx == LR_A) begin
            val = lr_dat;
        end else if (BYPASS != 0 && rd_en && idx == wr_idx) begin
            val = wr_dat;
        end
        return val;
    endfunction

    always_comb begin
        Reg_Rn = read_port(Rn, state_q, wr_rd_en, wr_lr_en, Rd,
                           data_write, return_address, regs_q[Rn]);
    end

    always_comb begin
        Reg_Rm = read_port(Rm, state_q, wr_rd_en, wr_lr_en, Rd,
                           data_write, return_address, regs_q[Rm]);
    end

    assign ready  = (state_q == ST_READY);
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rn, Rm, Rd;
    logic [63:0] data_write, return_address;
    logic [1:0]  reg_wr;
    logic        clr_req;

    logic [63:0] rn_b1, rm_b1, rn_b0, rm_b0;
    logic        ready_b1, ready_b0, wr_err_b1, wr_err_b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] mdl [32];
    bit          mready;
    int          clear_left;
    bit          mwr_err;

    reg_file_param #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .Rn(Rn), .Rm(Rm), .Rd(Rd),
        .data_write(data_write), .return_address(return_address),
        .reg_wr(reg_wr), .clr_req(clr_req),
        .Reg_Rn(rn_b1), .Reg_Rm(rm_b1), .ready(ready_b1), .wr_err(wr_err_b1)
    );

    reg_file_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .Rn(Rn), .Rm(Rm), .Rd(Rd),
        .data_write(data_write), .return_address(return_address),
        .reg_wr(reg_wr), .clr_req(clr_req),
        .Reg_Rn(rn_b0), .Reg_Rm(rm_b0), .ready(ready_b0), .wr_err(wr_err_b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reads as the file should present them: zero while clearing or for the
    // zero register; with forwarding, an in-flight write shows through
    // (link write taking precedence).
    function automatic logic [63:0] exp_read(input int idx, input bit byp);
        if (!mready || idx == 31) return 64'd0;
        if (byp && reg_wr[1] && idx == 30) return return_address;
        if (byp && reg_wr[0] && idx == int'(Rd) && Rd != 5'd31) return data_write;
        return mdl[idx];
    endfunction

    task automatic model_reset();
        mready     = 1'b0;
        clear_left = 32;
        mwr_err    = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    endtask

    task automatic model_edge();
        if (mready) begin
            if (reg_wr[0] && Rd != 5'd31) mdl[Rd] = data_write;
            if (reg_wr[1]) mdl[30] = return_address;
            mwr_err = 1'b0;
            if (clr_req) begin
                mready     = 1'b0;
                clear_left = 32;
                for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
            end
        end else begin
            mwr_err = (reg_wr != 2'd0);
            clear_left--;
            if (clear_left == 0) mready = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("ready_b1", {63'd0, ready_b1}, {63'd0, mready});
        chk("ready_b0", {63'd0, ready_b0}, {63'd0, mready});
        chk("wr_err_b1", {63'd0, wr_err_b1}, {63'd0, mwr_err});
        chk("wr_err_b0", {63'd0, wr_err_b0}, {63'd0, mwr_err});
        chk("Reg_Rn_b1", rn_b1, exp_read(int'(Rn), 1'b1));
        chk("Reg_Rm_b1", rm_b1, exp_read(int'(Rm), 1'b1));
        chk("Reg_Rn_b0", rn_b0, exp_read(int'(Rn), 1'b0));
        chk("Reg_Rm_b0", rm_b0, exp_read(int'(Rm), 1'b0));
    endtask

    // Called at a falling edge with inputs already set.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reg_wr  = 2'd0;
        clr_req = 1'b0;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sweep_reads();
        idle();
        for (int i = 0; i < 16; i++) begin
            Rn = 5'(2 * i);
            Rm = 5'(2 * i + 1);
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        Rn = '0; Rm = '0; Rd = '0;
        data_write = '0; return_address = '0;
        idle();
        model_reset();
        @(negedge clk);

        // Reset, then a full clear with no writes, then every register reads 0.
        apply_reset();
        for (int i = 0; i < 33; i++) cycle();
        sweep_reads();

        // Same-cycle forwarding vs stored value.
        Rd = 5'd5; data_write = 64'h1234; reg_wr = 2'd1; Rn = 5'd5; Rm = 5'd6;
        cycle();
        idle();
        cycle();
        chk("req033_after", rn_b0, 64'h1234);

        // Writes to the zero register are discarded.
        Rd = 5'd31; data_write = 64'hFFFF; reg_wr = 2'd1; Rn = 5'd31; Rm = 5'd5;
        cycle();
        idle();
        cycle();

        // Rd and link write to the same register: link value wins.
        Rd = 5'd30; data_write = 64'hAA; return_address = 64'h400; reg_wr = 2'd3;
        Rn = 5'd30; Rm = 5'd30;
        cycle();
        idle();
        cycle();
        chk("req035_r30", rn_b1, 64'h400);

        // Randomized traffic including occasional clears.
        for (int i = 0; i < 400; i++) begin
            Rn = 5'($urandom); Rm = 5'($urandom); Rd = 5'($urandom);
            data_write     = {$urandom, $urandom};
            return_address = {$urandom, $urandom};
            reg_wr  = 2'($urandom);
            clr_req = ($urandom_range(0, 49) == 0);
            cycle();
        end

        // Let any clear finish (bounded), then reset while ready with a live value.
        idle();
        for (int i = 0; i < 40 && !mready; i++) cycle();
        chk("ready_before_rst", {63'd0, ready_b1}, 64'd1);
        return_address = 64'hDEAD; reg_wr = 2'd2;
        cycle();
        idle(); Rn = 5'd30; Rm = 5'd30;
        cycle();
        apply_reset();
        for (int i = 0; i < 33; i++) cycle();
        sweep_reads();

        // Clear request, then a write attempted during the clear.
        Rd = 5'd3; data_write = 64'h55; Rn = 5'd3; Rm = 5'd30;
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 36; i++) begin
            reg_wr = (i == 2) ? 2'd1 : 2'd0;
            cycle();
        end
        sweep_reads();

        // Reset during a clear at count 10 restarts the full clear.
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        apply_reset();
        for (int i = 0; i < 34; i++) cycle();
        sweep_reads();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
- REQ-001 SHALL have parameter DATA_W, default 64, register data width in bits.
- REQ-002 SHALL have parameter NUM_REGS, default 32, number of registers (power of two, >=4); AW = log2(NUM_REGS).
- REQ-003 SHALL have parameter ZR_IDX, default NUM_REGS-1, zero register index: always reads 0, writes discarded.
- REQ-004 SHALL have parameter LR_IDX, default NUM_REGS-2, link register index, target of return_address writes.
- REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = reads return stored contents only.
- REQ-006 clk  input  1  single clock; all state updates on its rising edge.
- REQ-007 rst_n  input  1  asynchronous, active-low reset.
- REQ-008 Rn  input  AW  read port A index.
- REQ-009 Rm  input  AW  read port B index.
- REQ-010 Rd  input  AW  write index.
- REQ-011 data_write  input  DATA_W  write data for Rd.
- REQ-012 return_address  input  DATA_W  write data for LR_IDX.
- REQ-013 reg_wr  input  2  write mode: 0 none, 1 Rd, 2 link, 3 Rd and link.
- REQ-014 clr_req  input  1  request full-file clear, sampled only in READY.
- REQ-015 Reg_Rn  output  DATA_W  read port A data.
- REQ-016 Reg_Rm  output  DATA_W  read port B data.
- REQ-017 ready  output  1  high when the file accepts writes and returns valid reads.
- REQ-018 wr_err  output  1  registered one-cycle pulse when a write is dropped during clear.

Function
- REQ-019 SHALL implement a two-state FSM, CLEAR and READY, plus a clear counter cnt of width AW.
- REQ-020 In CLEAR, each rising edge SHALL write 0 to register[cnt] and increment cnt; at cnt==NUM_REGS-1, the next state SHALL be READY and cnt SHALL return to 0.
- REQ-021 In READY, clr_req=1 SHALL move the FSM to CLEAR on the next edge with cnt=0; writes presented in that same cycle SHALL still complete.
- REQ-022 ready SHALL be 1 exactly when the state is READY; clear SHALL take exactly NUM_REGS cycles.
- REQ-023 In READY, reg_wr bit0=1 and Rd!=ZR_IDX SHALL write data_write to register[Rd] at the edge.
- REQ-024 In READY, reg_wr bit1=1 SHALL write return_address to register[LR_IDX] at the edge.
- REQ-025 For reg_wr=3 with Rd==LR_IDX, return_address SHALL win.
- REQ-026 Reads SHALL be combinational: an index equal to ZR_IDX SHALL return 0; any read in CLEAR SHALL return 0.
- REQ-027 With BYPASS=1 in READY, a read index matching an active write target SHALL return that write's data (return_address priority per REQ-025); with BYPASS=0, the old value SHALL be returned.
- REQ-028 In CLEAR, any reg_wr!=0 SHALL be discarded and SHALL set wr_err=1 on the following cycle only; otherwise wr_err SHALL be 0.
- REQ-029 Register contents SHALL be unsigned bit vectors with no width conversion; out-of-range indices cannot occur because NUM_REGS is 2^AW.

Reset
- REQ-030 rst_n=0 SHALL immediately force state=CLEAR, cnt=0, ready=0, wr_err=0, with Reg_Rn and Reg_Rm reading 0, asynchronously to clk.
- REQ-031 Reset asserted mid-clear or mid-write SHALL abort the operation and restart the clear from cnt=0 after release; the array itself SHALL NOT be asynchronously reset.

Verification
- REQ-032 Release rst_n, then hold reg_wr=0 -> ready=0 for exactly 32 edges and rises after the 32nd; every register reads 0.
- REQ-033 In READY: Rd=5, data_write=0x1234, reg_wr=1, Rn=5 -> BYPASS=1: Reg_Rn=0x1234 in the same cycle; BYPASS=0: 0 then 0x1234 after the edge.
- REQ-034 Write Rd=31 with 0xFFFF, reg_wr=1, then read Rn=31 -> Reg_Rn=0.
- REQ-035 reg_wr=3, Rd=30, data_write=0xAA, return_address=0x400 -> register 30 = 0x400.
- REQ-036 Pulse clr_req in READY, then write reg_wr=1 during the clear -> ready low for 32 cycles, wr_err is a one-cycle pulse, all registers 0 afterwards.
- REQ-037 Assert rst_n=0 at cnt=10 during clear -> ready stays 0 and a full 32-cycle clear restarts after release.
